// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_ERET   = 3'd3,
        SRC_EXC    = 3'd4
    } redirect_src_e;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } pc_state_e;

    localparam int          DEF_ADDR_W       = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int          DEF_INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// Purpose: priority encoder picking the redirect source and its target (exc > eret > jump > branch > seq).
// Latency: purely combinational, zero cycles.
// Backpressure: none; stall handling lives in the caller.
module pc_redirect_sel
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic              jump_valid,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] epc,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    output redirect_src_e     src,
    output logic [ADDR_W-1:0] target
);

    always_comb begin
        src    = SRC_SEQ;
        target = '0;
        if (exc_valid) begin
            src    = SRC_EXC;
            target = EXC_VECTOR;
        end else if (eret_valid) begin
            src    = SRC_ERET;
            target = epc;
        end else if (jump_valid) begin
            src    = SRC_JUMP;
            target = jump_target;
        end else if (branch_taken) begin
            src    = SRC_BRANCH;
            target = branch_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Purpose: fetch-stage PC with EPC ownership; a redirect seen during a stall is held until pc_write returns.
// Latency: one cycle from sampled redirect/enable to pc_out. Optional PC_ALIGN_CHECK_EN adds misaligned_fetch.
// Backpressure: pc_write=0 holds the PC; exceptions are taken regardless of pc_write.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
    parameter int                INSTR_BYTES  = DEF_INSTR_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              eret_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic [ADDR_W-1:0] epc_out,
    output logic              redirect_pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misaligned_fetch
`endif
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pc_load;
    redirect_src_e     sel_src;
    logic [ADDR_W-1:0] sel_tgt;

    pc_redirect_sel #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .exc_valid     (exc_valid),
        .eret_valid    (eret_valid),
        .jump_valid    (jump_valid),
        .branch_taken  (branch_taken),
        .epc           (epc_q),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .src           (sel_src),
        .target        (sel_tgt)
    );

    assign pc_next_seq = pc_q + ADDR_W'(INSTR_BYTES);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_tgt_d = pend_tgt_q;
        pc_load    = 1'b0;
        if (sel_src == SRC_EXC) begin
            pc_d    = sel_tgt;
            epc_d   = exc_pc;
            state_d = ST_IDLE;
            pc_load = 1'b1;
        end else if (state_q == ST_PENDING) begin
            // The held redirect is from an older instruction, so newer ones are dropped.
            if (pc_write) begin
                pc_d    = pend_tgt_q;
                state_d = ST_IDLE;
                pc_load = 1'b1;
            end
        end else if (pc_write) begin
            pc_d    = (sel_src == SRC_SEQ) ? pc_next_seq : sel_tgt;
            pc_load = 1'b1;
        end else if (sel_src != SRC_SEQ) begin
            pend_tgt_d = sel_tgt;
            state_d    = ST_PENDING;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_out           = pc_q;
    assign epc_out          = epc_q;
    assign redirect_pending = (state_q == ST_PENDING);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic misaligned_q, misaligned_d;

    always_comb begin
        misaligned_d = misaligned_q;
        if (pc_load) begin
            misaligned_d = |(pc_d & ALIGN_MASK);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign misaligned_fetch = misaligned_q;
`else
    logic unused_load;
    assign unused_load = pc_load;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven check of pc_unit: each vector is one clock of stimulus with the expected post-edge state.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        eret_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_next_seq;
    logic [31:0] epc_out;
    logic        redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned_fetch;
`endif

    pc_unit dut (
        .clock            (clock),
        .reset            (reset),
        .pc_write         (pc_write),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump_valid       (jump_valid),
        .jump_target      (jump_target),
        .exc_valid        (exc_valid),
        .exc_pc           (exc_pc),
        .eret_valid       (eret_valid),
        .pc_out           (pc_out),
        .pc_next_seq      (pc_next_seq),
        .epc_out          (epc_out),
        .redirect_pending (redirect_pending)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned_fetch (misaligned_fetch)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        pw;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        exc;
        logic [31:0] xpc;
        logic        eret;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
        logic        mis;
        int          idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_vec    = 0;

    function automatic vec_t mk(input logic rst, input logic pw, input logic br, input logic [31:0] brt,
                                input logic j, input logic [31:0] jt, input logic exc, input logic [31:0] xpc,
                                input logic eret, input logic [31:0] e_pc, input logic [31:0] e_epc,
                                input logic e_pend, input logic e_mis);
        vec_t v;
        v.rst = rst; v.pw = pw; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
        v.exc = exc; v.xpc = xpc; v.eret = eret;
        v.e_pc = e_pc; v.e_epc = e_epc; v.e_pend = e_pend; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clock);
        reset         = v.rst;
        pc_write      = v.pw;
        branch_taken  = v.br;
        branch_target = v.brt;
        jump_valid    = v.j;
        jump_target   = v.jt;
        exc_valid     = v.exc;
        exc_pc        = v.xpc;
        eret_valid    = v.eret;
        e.pc = v.e_pc; e.epc = v.e_epc; e.pend = v.e_pend; e.mis = v.e_mis; e.idx = n_vec;
        sb_q.push_back(e);
        n_vec++;
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard empty at vec %0d", n_vec);
        end else begin
            e = sb_q.pop_front();
            check32("pc_out", e.idx, pc_out, e.pc);
            check32("pc_next_seq", e.idx, pc_next_seq, e.pc + 32'd4);
            check32("epc_out", e.idx, epc_out, e.epc);
            check32("redirect_pending", e.idx, {31'd0, redirect_pending}, {31'd0, e.pend});
`ifdef PC_ALIGN_CHECK_EN
            check32("misaligned_fetch", e.idx, {31'd0, misaligned_fetch}, {31'd0, e.mis});
`endif
        end
    endtask

    vec_t tbl[28];

    initial begin
        reset = 1'b1; pc_write = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump_valid = 1'b0; jump_target = '0; exc_valid = 1'b0; exc_pc = '0; eret_valid = 1'b0;

        //             rst pw  br  brt           j   jt            exc xpc           eret  pc            epc           pend mis
        tbl[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 32'h0,      0, 0);
        tbl[1]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 32'h0,      0, 0);
        tbl[2]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 32'h0,      0, 0);
        tbl[3]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_000C, 32'h0,      0, 0);
        tbl[4]  = mk(0, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0, 32'h0000_0100, 32'h0,      0, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,        1, 32'h400,      0, 32'h0,        0, 32'h0000_0100, 32'h0,      1, 0);
        tbl[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0100, 32'h0,      1, 0);
        tbl[7]  = mk(0, 0, 1, 32'h500,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0100, 32'h0,      1, 0);
        tbl[8]  = mk(0, 1, 0, 32'h0,        1, 32'h600,      0, 32'h0,        0, 32'h0000_0400, 32'h0,      0, 0);
        tbl[9]  = mk(0, 1, 1, 32'h200,      1, 32'h300,      0, 32'h0,        0, 32'h0000_0300, 32'h0,      0, 0);
        tbl[10] = mk(0, 1, 1, 32'h200,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0200, 32'h0,      0, 0);
        tbl[11] = mk(0, 0, 1, 32'h800,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0200, 32'h0,      1, 0);
        tbl[12] = mk(0, 0, 1, 32'h800,      0, 32'h0,        1, 32'h1234,     0, 32'h8000_0180, 32'h1234,   0, 0);
        tbl[13] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h0000_1234, 32'h1234,   0, 0);
        tbl[14] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h2000,     1, 32'h8000_0180, 32'h2000,   0, 0);
        tbl[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8000_0180, 32'h2000,   1, 0);
        tbl[16] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_2000, 32'h2000,   0, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_2000, 32'h2000,   0, 0);
        tbl[18] = mk(0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h2000,   0, 0);
        tbl[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 32'h2000,   0, 0);
        tbl[20] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 32'h2000,   0, 0);
        tbl[21] = mk(0, 0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        0, 32'h0000_0004, 32'h2000,   1, 0);
        tbl[22] = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 32'h0,      0, 0);
        tbl[23] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 32'h0,      0, 0);
        tbl[24] = mk(0, 1, 0, 32'h0,        1, 32'h402,      0, 32'h0,        0, 32'h0000_0402, 32'h0,      0, 1);
        tbl[25] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0406, 32'h0,      0, 1);
        tbl[26] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0000_0406, 32'h0,      0, 1);
        tbl[27] = mk(0, 1, 0, 32'h0,        1, 32'h500,      0, 32'h0,        0, 32'h0000_0500, 32'h0,      0, 0);

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i]);
        end

        // Exception during a held redirect, with a newer jump in the same cycle, then resume from the vector.
        apply(mk(0, 1, 0, 32'h0,   1, 32'h700, 0, 32'h0,  0, 32'h0000_0700, 32'h0,  0, 0));
        apply(mk(0, 0, 1, 32'h900, 0, 32'h0,   0, 32'h0,  0, 32'h0000_0700, 32'h0,  1, 0));
        apply(mk(0, 0, 0, 32'h0,   1, 32'h999, 1, 32'h55, 0, 32'h8000_0180, 32'h55, 0, 0));
        apply(mk(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h8000_0184, 32'h55, 0, 0));

        // ERET while held: target is the EPC at capture time, released after two stall cycles.
        apply(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1, 32'h8000_0184, 32'h55, 1, 0));
        apply(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h8000_0184, 32'h55, 1, 0));
        apply(mk(0, 1, 1, 32'h44,  0, 32'h0,   0, 32'h0,  0, 32'h0000_0055, 32'h55, 0, 1));

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard residue: %0d entries left, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
